// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter: FSM states,
// transfer size codes, default widths and request-enable constants.
package fetch_mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned MAX_DATA_RUN_DEF = 4;

    // Transfer size codes carried on data_size / bus_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Bus request / handshake levels
    localparam logic REQ_ENABLE  = 1'b1;
    localparam logic REQ_DISABLE = 1'b0;
    localparam logic HS_OK       = 1'b1;
    localparam logic HS_NONE     = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } arb_state_e;

endpackage

// File: rtl/fetch_mem_arbiter_req_latch.sv
// fma_req_latch: holds the bus-side request fields (wr/size/wstrb/addr/wdata)
// of the currently granted requester. Loaded once per grant, cleared by reset.
module fma_req_latch
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [3:0]        i_wstrb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_wdata,
    output logic              o_wr,
    output logic [1:0]        o_size,
    output logic [3:0]        o_wstrb,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_wdata
);

    // Capture the granted request fields; hold them for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wr    <= 1'b0;
            o_size  <= '0;
            o_wstrb <= '0;
            o_addr  <= '0;
            o_wdata <= '0;
        end else if (i_load) begin
            o_wr    <= i_wr;
            o_size  <= i_size;
            o_wstrb <= i_wstrb;
            o_addr  <= i_addr;
            o_wdata <= i_wdata;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one SRAM-like port between instruction fetch and
// the MEM stage. One transaction outstanding, data has priority, a flushed
// fetch still completes on the bus but its handshakes are hidden.
// Optional build macro: ARB_STARVE_GUARD_EN (bounded run of data grants
// while a fetch waits; undefined = strict data priority).
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [ADDR_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [ADDR_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [ADDR_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [ADDR_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [ADDR_W-1:0] bus_rdata
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_cancel;
    logic       w_cancel_nxt;
    logic       w_grant_d;
    logic       w_grant_i;
    logic       w_force_inst;
    logic       w_hide_inst;

    logic              w_ld_wr;
    logic [1:0]        w_ld_size;
    logic [3:0]        w_ld_wstrb;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [ADDR_W-1:0] w_ld_wdata;

    // A flush in the current cycle hides the fetch handshake immediately
    assign w_hide_inst = r_cancel | flush;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);
    logic [RUN_W-1:0] r_run;

    assign w_force_inst = (r_run >= RUN_W'(MAX_DATA_RUN)) && inst_req && !flush;

    // Count data grants that overtook a waiting fetch; clear once fetch is served or gone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_i || !inst_req) begin
                r_run <= '0;
            end else if (w_grant_d && (r_run < RUN_W'(MAX_DATA_RUN))) begin
                r_run <= r_run + 1'b1;
            end
        end
    end
`else
    assign w_force_inst = 1'b0;
    // MAX_DATA_RUN only shapes the starvation guard; kept so both builds share one interface
    if (MAX_DATA_RUN == 0) begin : g_no_guard
    end
`endif

    // State and cancel registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cancel <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cancel <= w_cancel_nxt;
        end
    end

    // Grant decision, handshake pass-through and next state
    always_comb begin
        w_state_nxt  = r_state;
        w_cancel_nxt = r_cancel;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        bus_req      = REQ_DISABLE;
        inst_addr_ok = HS_NONE;
        inst_data_ok = HS_NONE;
        data_addr_ok = HS_NONE;
        data_data_ok = HS_NONE;

        case (r_state)
            ST_IDLE: begin
                w_cancel_nxt = 1'b0;
                if (data_req && !w_force_inst) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_D_ADDR;
                end else if (inst_req && !flush) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_I_ADDR;
                end
            end
            ST_I_ADDR: begin
                bus_req = REQ_ENABLE;
                if (flush) w_cancel_nxt = 1'b1;
                if (bus_addr_ok == HS_OK) begin
                    inst_addr_ok = !w_hide_inst;
                    w_state_nxt  = ST_I_DATA;
                end
            end
            ST_I_DATA: begin
                if (flush) w_cancel_nxt = 1'b1;
                if (bus_data_ok == HS_OK) begin
                    inst_data_ok = !w_hide_inst;
                    w_cancel_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_D_ADDR: begin
                bus_req = REQ_ENABLE;
                if (bus_addr_ok == HS_OK) begin
                    data_addr_ok = HS_OK;
                    w_state_nxt  = ST_D_DATA;
                end
            end
            ST_D_DATA: begin
                if (bus_data_ok == HS_OK) begin
                    data_data_ok = HS_OK;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_cancel_nxt = 1'b0;
            end
        endcase

        // Reset takes effect on the outputs in the same cycle it is asserted
        if (rst) begin
            bus_req      = REQ_DISABLE;
            inst_addr_ok = HS_NONE;
            inst_data_ok = HS_NONE;
            data_addr_ok = HS_NONE;
            data_data_ok = HS_NONE;
        end
    end

    // Select which requester's fields are loaded into the bus latch
    always_comb begin
        if (w_grant_d) begin
            w_ld_wr    = data_wr;
            w_ld_size  = data_size;
            w_ld_wstrb = data_wstrb;
            w_ld_addr  = data_addr;
            w_ld_wdata = data_wdata;
        end else begin
            w_ld_wr    = 1'b0;
            w_ld_size  = SIZE_WORD;
            w_ld_wstrb = '0;
            w_ld_addr  = inst_addr;
            w_ld_wdata = '0;
        end
    end

    fma_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_req_latch (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_grant_d | w_grant_i),
        .i_wr    (w_ld_wr),
        .i_size  (w_ld_size),
        .i_wstrb (w_ld_wstrb),
        .i_addr  (w_ld_addr),
        .i_wdata (w_ld_wdata),
        .o_wr    (bus_wr),
        .o_size  (bus_size),
        .o_wstrb (bus_wstrb),
        .o_addr  (bus_addr),
        .o_wdata (bus_wdata)
    );

    assign inst_rdata = inst_data_ok ? bus_rdata : '0;
    assign data_rdata = data_data_ok ? bus_rdata : '0;

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares one SRAM-like memory port (req/addr_ok/data_ok) between the instruction-fetch requester (PC stage) and the data requester (MEM stage).
- Allows one outstanding transaction at a time; data side has priority.
- Sits between the fetch/MEM stages and the cache/AXI bridge.
- Handles pipeline flush: an in-flight fetch is completed on the bus but its response is discarded.

Parameters:
- ADDR_W, 32, address/data width
- MAX_DATA_RUN, 4, consecutive data grants allowed while a fetch waits (starvation guard only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush/exception; cancels fetch
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  ADDR_W  fetch data
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1=write
- data_size  in  2  0=byte, 1=half, 2=word
- data_wstrb  in  4  byte enables
- data_addr  in  ADDR_W  data address
- data_wdata  in  ADDR_W  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data done / read data valid
- data_rdata  out  ADDR_W  read data
- bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/1/2/4/ADDR_W/ADDR_W  to memory
- bus_addr_ok, bus_data_ok  in  1  memory handshake
- bus_rdata  in  ADDR_W  memory read data

Behaviour:
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. Reset and rst=1 (any state, mid-transaction included) force:
  - state=IDLE, cancel=0, run counter=0
  - all *_ok outputs=0, bus_req=0, bus_* registers=0
  - a pending bus response after reset is ignored.
- IDLE grant:
  - data_req=1 → latch data fields, go to D_ADDR.
  - Else inst_req=1 and flush=0 → latch inst_addr (bus_wr=0, size=2, wstrb=0), go to I_ADDR.
  - flush=1 in IDLE blocks an inst grant that cycle.
- Latency: request sampled in cycle N; bus_req=1 from cycle N+1, driven from latched registers.
- X_ADDR states:
  - bus_req=1.
  - On bus_addr_ok: pulse the requester's *_addr_ok in the same cycle (combinational pass-through), go to X_DATA, bus_req=0 next cycle.
  - bus_req is never retracted before bus_addr_ok.
- X_DATA states:
  - On bus_data_ok: pass the requester's *_data_ok and *_rdata through in the same cycle, return to IDLE.
  - A new grant is possible the following cycle (min 3 cycles per transaction).
- Flush:
  - flush=1 in I_ADDR or I_DATA sets cancel. inst_addr_ok and inst_data_ok are suppressed for the rest of that transaction, while the bus handshake still completes.
  - cancel clears on return to IDLE.
  - flush does not affect D_* states.
- inst_rdata/data_rdata are 0 when the matching *_data_ok=0.
- bus_addr_ok/bus_data_ok arriving in IDLE or in the wrong phase are ignored.
- Simultaneous data_req and inst_req in IDLE: data wins, unless the starvation guard applies.

Optional Feature:
- ARB_STARVE_GUARD_EN defined:
  - Counter increments on each data grant made while inst_req=1; resets on any inst grant, or when inst_req=0 in IDLE.
  - At MAX_DATA_RUN, the next IDLE grant goes to inst (if inst_req=1 and flush=0) even with data_req=1.
- Not defined: strict data priority; no counter logic.

Decomposition:
- Shared package/defines file: FSM state encodings, size codes (SIZE_BYTE/HALF/WORD), ADDR_W default, the RequestEnable/AddrOK-style constants.
- Sub-module: fma_req_latch, holding the latched bus_* fields with a load enable. Instantiate once and mux its input by grant.

Test Plan:
- Lone fetch: inst_req=1, addr=0xBFC00000; bus_addr_ok 1 cycle after bus_req, bus_data_ok 2 cycles later with 0x3C080001 → bus_req at N+1, bus_addr=0xBFC00000, inst_addr_ok pulses with bus_addr_ok, inst_data_ok=1 with inst_rdata=0x3C080001, back in IDLE.
- Collision: inst_req and data_req (read, 0x80001000) both high at cycle 0 → data served first (bus_addr=0x80001000, bus_wr=0), then fetch; exactly one *_data_ok per requester.
- Flush during I_DATA: flush=1 one cycle before bus_data_ok → inst_data_ok stays 0, FSM returns to IDLE, next fetch granted normally.
- Write: data_wr=1, size=0, wstrb=4'b0100, wdata=0x00AB0000 → bus fields match exactly; data_data_ok on bus_data_ok.
- Reset mid-transaction: rst=1 during D_ADDR → next cycle bus_req=0, all ok outputs 0, IDLE; a late bus_data_ok produces no data_data_ok.
- ARB_STARVE_GUARD_EN, MAX_DATA_RUN=4: data_req and inst_req held high continuously → grant pattern D,D,D,D,I repeating.
